// File: rtl/gcd16_sync_host_if.sv
// Signal bundle between the clocked host and its environment: operand/result ports,
// the gcd core's four-phase x/y/z channels, activate, and status outputs.
interface gcd16_sync_host_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_z;

    logic             activate_0r;
    logic             activate_0a;

    logic             x_0r;
    logic             x_0a;
    logic [WIDTH-1:0] x_0d;
    logic             y_0r;
    logic             y_0a;
    logic [WIDTH-1:0] y_0d;
    logic             z_0r;
    logic             z_0a;
    logic [WIDTH-1:0] z_0d;

    logic [15:0]      op_count;
    logic             proto_err;

    // master: the environment (operand source, result sink, gcd core)
    modport master (
        output in_valid, in_x, in_y, res_ready, activate_0a,
               x_0r, y_0r, z_0r, z_0d,
        input  in_ready, res_valid, res_z, activate_0r,
               x_0a, x_0d, y_0a, y_0d, z_0a, op_count, proto_err
    );

    // slave: the clocked host
    modport slave (
        input  in_valid, in_x, in_y, res_ready, activate_0a,
               x_0r, y_0r, z_0r, z_0d,
        output in_ready, res_valid, res_z, activate_0r,
               x_0a, x_0d, y_0a, y_0d, z_0a, op_count, proto_err
    );
endinterface

// File: rtl/gcd16_sync_host.sv
// Clocked host for an async four-phase gcd core: serves x/y pulls from an operand register, sinks z pushes.
// Latency: x_0r rise to x_0a rise SYNC_STAGES+2 clk; z_0r rise to z_0a rise SYNC_STAGES+1 clk.
// Backpressure: in_ready low while operands are unfetched; z_0a held low while a result is unconsumed.
module gcd16_sync_host #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              initialise_n,
    gcd16_sync_host_if.slave  bus
);
    typedef enum logic [1:0] {CH_IDLE, CH_DATA, CH_ACK} ch_state_t;
    typedef enum logic       {ZIDLE, ZACK}              z_state_t;

    // Synchronizers for {activate_0a, z_0r, y_0r, x_0r}
    logic [3:0] sync_raw;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_s;
    logic [2:0] req_prev;
    logic       x_s, y_s, z_s, act_s;

    assign sync_raw = {bus.activate_0a, bus.z_0r, bus.y_0r, bus.x_0r};
    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign x_s      = sync_s[0];
    assign y_s      = sync_s[1];
    assign z_s      = sync_s[2];
    assign act_s    = sync_s[3];

    always_ff @(posedge clk or negedge initialise_n) begin
        if (!initialise_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            req_prev <= '0;
        end else begin
            sync_q[0] <= sync_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            req_prev <= sync_s[2:0];
        end
    end

    ch_state_t        x_st, x_st_n, y_st, y_st_n;
    z_state_t         z_st, z_st_n;
    logic             x_0a_q, x_0a_n, y_0a_q, y_0a_n, z_0a_q, z_0a_n;
    logic [WIDTH-1:0] x_0d_q, x_0d_n, y_0d_q, y_0d_n;
    logic [WIDTH-1:0] opx, opy, res_z_q;
    logic             x_pend, y_pend, res_valid_q;
    logic             x_done, y_done, z_cap;
    logic             x_fall, y_fall, z_fall;
    logic             activate_q, proto_err_q;
    logic [15:0]      op_count_q;
    logic             accept;

    assign accept = bus.in_valid && !x_pend && !y_pend;

    // A request dropping before its ack is a broken four-phase cycle
    assign x_fall = req_prev[0] && !x_s && !x_0a_q;
    assign y_fall = req_prev[1] && !y_s && !y_0a_q;
    assign z_fall = req_prev[2] && !z_s && !z_0a_q;

    always_comb begin
        x_st_n = x_st;
        x_0a_n = x_0a_q;
        x_0d_n = x_0d_q;
        x_done = 1'b0;
        case (x_st)
            CH_IDLE: if (x_s && x_pend) begin
                x_0d_n = opx;
                x_st_n = CH_DATA;
            end
            CH_DATA: if (!x_s) begin
                x_st_n = CH_IDLE;
            end else begin
                x_0a_n = 1'b1;
                x_st_n = CH_ACK;
            end
            CH_ACK: if (!x_s) begin
                x_0a_n = 1'b0;
                x_done = 1'b1;
                x_st_n = CH_IDLE;
            end
            default: x_st_n = CH_IDLE;
        endcase
    end

    always_comb begin
        y_st_n = y_st;
        y_0a_n = y_0a_q;
        y_0d_n = y_0d_q;
        y_done = 1'b0;
        case (y_st)
            CH_IDLE: if (y_s && y_pend) begin
                y_0d_n = opy;
                y_st_n = CH_DATA;
            end
            CH_DATA: if (!y_s) begin
                y_st_n = CH_IDLE;
            end else begin
                y_0a_n = 1'b1;
                y_st_n = CH_ACK;
            end
            CH_ACK: if (!y_s) begin
                y_0a_n = 1'b0;
                y_done = 1'b1;
                y_st_n = CH_IDLE;
            end
            default: y_st_n = CH_IDLE;
        endcase
    end

    always_comb begin
        z_st_n = z_st;
        z_0a_n = z_0a_q;
        z_cap  = 1'b0;
        case (z_st)
            ZIDLE: if (z_s && !res_valid_q) begin
                z_cap  = 1'b1;
                z_0a_n = 1'b1;
                z_st_n = ZACK;
            end
            ZACK: if (!z_s) begin
                z_0a_n = 1'b0;
                z_st_n = ZIDLE;
            end
            default: z_st_n = ZIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge initialise_n) begin
        if (!initialise_n) begin
            x_st        <= CH_IDLE;
            y_st        <= CH_IDLE;
            z_st        <= ZIDLE;
            x_0a_q      <= 1'b0;
            y_0a_q      <= 1'b0;
            z_0a_q      <= 1'b0;
            x_0d_q      <= '0;
            y_0d_q      <= '0;
            opx         <= '0;
            opy         <= '0;
            x_pend      <= 1'b0;
            y_pend      <= 1'b0;
            res_z_q     <= '0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
            activate_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            x_st        <= x_st_n;
            y_st        <= y_st_n;
            z_st        <= z_st_n;
            x_0a_q      <= x_0a_n;
            y_0a_q      <= y_0a_n;
            z_0a_q      <= z_0a_n;
            x_0d_q      <= x_0d_n;
            y_0d_q      <= y_0d_n;
            activate_q  <= 1'b1;
            proto_err_q <= proto_err_q | act_s | x_fall | y_fall | z_fall;

            if (accept) begin
                opx    <= bus.in_x;
                opy    <= bus.in_y;
                x_pend <= 1'b1;
                y_pend <= 1'b1;
            end else begin
                if (x_done) x_pend <= 1'b0;
                if (y_done) y_pend <= 1'b0;
            end

            if (z_cap) begin
                res_z_q     <= bus.z_0d;
                res_valid_q <= 1'b1;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
                op_count_q  <= op_count_q + 16'd1;
            end
        end
    end

    assign bus.in_ready    = !x_pend && !y_pend;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_z       = res_z_q;
    assign bus.activate_0r = activate_q;
    assign bus.x_0a        = x_0a_q;
    assign bus.x_0d        = x_0d_q;
    assign bus.y_0a        = y_0a_q;
    assign bus.y_0d        = y_0d_q;
    assign bus.z_0a        = z_0a_q;
    assign bus.op_count    = op_count_q;
    assign bus.proto_err   = proto_err_q;
endmodule

// File: tb/tb_gcd16_sync_host.sv
// Bench for gcd16_sync_host: a behavioural four-phase gcd core plus directed operand/result traffic.
module tb_gcd16_sync_host;
    localparam int WIDTH = 16;
    localparam int SYNC  = 2;

    localparam int P_IN_READY  = 0;
    localparam int P_RES_VALID = 1;
    localparam int P_X_ACK     = 2;
    localparam int P_Z_ACK_LOW = 3;

    logic clk = 1'b0;
    logic initialise_n = 1'b0;
    always #5 clk = ~clk;

    gcd16_sync_host_if #(.WIDTH(WIDTH)) bus();

    gcd16_sync_host #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .initialise_n (initialise_n),
        .bus          (bus.slave)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_count;
    logic        seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p, q, t;
        p = a;
        q = b;
        while (q != 16'd0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Behavioural core: pull x, pull y, push gcd on z, forever while activated
    int          cst;
    logic [15:0] ax, ay, xd_prev;
    initial begin
        bus.x_0r = 1'b0;
        bus.y_0r = 1'b0;
        bus.z_0r = 1'b0;
        bus.z_0d = '0;
        cst = 0;
        ax = '0;
        ay = '0;
        xd_prev = '0;
        forever begin
            @(negedge clk);
            if (!initialise_n) begin
                bus.x_0r = 1'b0;
                bus.y_0r = 1'b0;
                bus.z_0r = 1'b0;
                cst = 0;
            end else begin
                case (cst)
                    0: if (bus.activate_0r) begin bus.x_0r = 1'b1; cst = 1; end
                    1: if (bus.x_0a) begin
                        check("x_0d_stable_before_ack", bus.x_0d, xd_prev);
                        ax = bus.x_0d;
                        bus.x_0r = 1'b0;
                        cst = 2;
                    end
                    2: if (!bus.x_0a) begin bus.y_0r = 1'b1; cst = 3; end
                    3: if (bus.y_0a) begin
                        check("in_ready_low_until_y_done", bus.in_ready, 0);
                        ay = bus.y_0d;
                        bus.y_0r = 1'b0;
                        cst = 4;
                    end
                    4: if (!bus.y_0a) begin
                        bus.z_0d = gcd(ax, ay);
                        bus.z_0r = 1'b1;
                        cst = 5;
                    end
                    5: if (bus.z_0a) begin bus.z_0r = 1'b0; cst = 6; end
                    6: if (!bus.z_0a) cst = 0;
                    default: cst = 0;
                endcase
            end
            xd_prev = bus.x_0d;
        end
    end

    function automatic logic probe(input int which);
        case (which)
            P_IN_READY:  return bus.in_ready;
            P_RES_VALID: return bus.res_valid;
            P_X_ACK:     return bus.x_0a;
            P_Z_ACK_LOW: return !bus.z_0a;
            default:     return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int which, input string tag);
        int n;
        n = 0;
        while (!probe(which) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_wait"}, probe(which), 1);
    endtask

    task automatic offer(input logic [15:0] x, input logic [15:0] y, input string tag);
        wait_until(P_IN_READY, tag);
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_y = y;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic take_res(input string tag);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check({tag, "_op_count"}, bus.op_count, exp_count);
    endtask

    task automatic get_result(input logic [15:0] exp, input string tag);
        wait_until(P_RES_VALID, tag);
        check({tag, "_res_z"}, bus.res_z, exp);
        take_res(tag);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.res_ready = 1'b0;
        bus.activate_0a = 1'b0;
        exp_count = '0;

        // 1: reset state, then a single gcd
        initialise_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_activate", bus.activate_0r, 0);
        check("rst_acks", {bus.x_0a, bus.y_0a, bus.z_0a}, 0);
        check("rst_op_count", bus.op_count, 0);
        check("rst_proto_err", bus.proto_err, 0);
        initialise_n = 1'b1;
        @(posedge clk); #1;
        check("activate_after_rst", bus.activate_0r, 1);
        offer(16'd10000, 16'd1000, "t1_in");
        get_result(16'd1000, "t1");
        check("t1_proto_err", bus.proto_err, 0);

        // 2+3: back-to-back pairs with the first result held for 50 clk
        offer(16'd1000, 16'd10000, "t2_in_a");
        check("t2_in_ready_busy", bus.in_ready, 0);
        offer(16'd48, 16'd18, "t2_in_b");
        wait_until(P_RES_VALID, "t3_first");
        check("t3_first_res_z", bus.res_z, 1000);
        wait_until(P_Z_ACK_LOW, "t3_first_ack_done");
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.z_0a) seen = 1'b1;
        end
        check("t3_z_0a_held_low", seen, 0);
        check("t3_core_waiting", bus.z_0r, 1);
        check("t3_res_still_first", bus.res_z, 1000);
        take_res("t3_first");
        get_result(16'd6, "t3_second");

        // 4: core requests x before any operand is offered
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.x_0a) seen = 1'b1;
        end
        check("t4_no_early_x_ack", seen, 0);
        check("t4_core_requesting", bus.x_0r, 1);
        offer(16'd100, 16'd75, "t4_in");
        wait_until(P_X_ACK, "t4_x_ack");
        check("t4_x_0d", bus.x_0d, 100);
        get_result(16'd25, "t4");

        // 5: async reset in the middle of an x handshake
        offer(16'd10000, 16'd1000, "t5_in");
        wait_until(P_X_ACK, "t5_x_ack");
        initialise_n = 1'b0;
        #1;
        check("t5_x_0a", bus.x_0a, 0);
        check("t5_x_0d", bus.x_0d, 0);
        check("t5_activate", bus.activate_0r, 0);
        check("t5_in_ready", bus.in_ready, 1);
        check("t5_op_count", bus.op_count, 0);
        check("t5_res_valid", bus.res_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        initialise_n = 1'b1;
        exp_count = '0;
        offer(16'd10000, 16'd1000, "t5_rerun_in");
        get_result(16'd1000, "t5_rerun");

        // 6: stray activate ack pulse
        check("t6_proto_err_before", bus.proto_err, 0);
        bus.activate_0a = 1'b1;
        @(posedge clk); #1;
        bus.activate_0a = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        check("t6_proto_err_set", bus.proto_err, 1);
        check("t6_activate_held", bus.activate_0r, 1);
        repeat (10) @(posedge clk);
        #1;
        check("t6_proto_err_sticky", bus.proto_err, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
